// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART receive path (and a future uart_tx).
//   UART_DATA_W : data bits per character
//   rx_state_e  : receiver FSM states
//   calc_div    : clocks per bit from clock and line rate (truncated)
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead output.
//   i_clk, i_rst_n    clock, async active-low reset
//   i_push, i_wdata   write request; ignored when full unless a pop happens in the same cycle
//   i_pop             pop head; ignored when empty
//   o_rdata           head entry (0 while empty)
//   o_full, o_empty   status
//   o_count           occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (8N1, LSB first) feeding a show-ahead byte FIFO.
//   clk, reset_n      system clock, async active-low reset
//   ser_rx            serial line, idle high, asynchronous
//   rd_en             pop FIFO head (ignored when empty)
//   rd_data, rd_valid FIFO head byte and not-empty
//   count             FIFO occupancy
//   frame_err         sticky: stop bit sampled low
//   overrun           sticky: byte completed while FIFO full (byte dropped)
//   parity_err        sticky: even-parity mismatch (tied 0 without parity)
//   clr_err           clears sticky flags; a coincident new error wins
// Build option: define UART_RX_PARITY_EN for 8E1 frames (parity bit after bit 7).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ser_rx,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   parity_err,
  input  logic                   clr_err
);

  localparam int DIV  = calc_div(CLK_HZ, BAUD);
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  rx_state_e              r_state;
  logic                   r_sync1;
  logic                   r_rx_s;
  logic                   r_armed;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_bit;
  logic [UART_DATA_W-1:0] r_shift;
  logic                   r_frame_err;
  logic                   r_overrun;

  logic w_tick;
  logic w_push;
  logic w_ferr_set;
  logic w_ovr_set;
  logic w_full;
  logic w_empty;

  // Synchroniser resets to the idle line level so reset never fakes a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= ser_rx;
      r_rx_s  <= r_sync1;
    end
  end

  // Sample strobe: half a bit into the start bit, then one full bit apart.
  assign w_tick = (r_state == ST_START) ? (r_cnt == CW'(HALF - 1))
                                        : (r_cnt == CW'(DIV - 1));

  assign w_push     = (r_state == ST_STOP) && w_tick &&  r_rx_s;
  assign w_ferr_set = (r_state == ST_STOP) && w_tick && !r_rx_s;
  assign w_ovr_set  = w_push && w_full && !(rd_en && !w_empty);

  // r_armed is set only after the line is seen high in IDLE, so a low line
  // (break or bad stop) cannot restart a frame until it returns high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_armed <= 1'b0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          if (r_rx_s)       r_armed <= 1'b1;
          else if (r_armed) r_state <= ST_START;
        end
        ST_START: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_state <= r_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s, r_shift[UART_DATA_W-1:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            if (!r_rx_s) r_armed <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= (r_frame_err & ~clr_err) | w_ferr_set;
      r_overrun   <= (r_overrun   & ~clr_err) | w_ovr_set;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_parity_err;
  logic w_par_set;

  // Even parity: the parity bit equals the XOR of the data bits.
  assign w_par_set = (r_state == ST_PARITY) && w_tick && (r_rx_s != ^r_shift);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_parity_err <= 1'b0;
    else          r_parity_err <= (r_parity_err & ~clr_err) | w_par_set;
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign rd_valid  = !w_empty;

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_wdata (r_shift),
    .i_pop   (rd_en),
    .o_rdata (rd_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

endmodule
